// File: rtl/bpu_gshare_ras_pkg.sv
// bpu_gshare_ras_pkg: branch-type encoding and fetch-step constant shared by the predictor
package bpu_gshare_ras_pkg;
    typedef enum logic [1:0] {NONE = 2'd0, IMME = 2'd1, CALL = 2'd2, RETN = 2'd3} bpu_type_e;
    localparam logic [31:0] PC_STEP = 32'd8;
endpackage

// File: rtl/bpu_ras.sv
// bpu_ras: circular return-address stack; a full push overwrites the oldest entry, an empty pop is ignored
module bpu_ras #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] push_data_i,
    output logic [31:0] top_data_o,
    output logic        empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            ptr_q <= ptr_q + PW'(1);
            cnt_q <= cnt_q == CW'(DEPTH) ? cnt_q : cnt_q + CW'(1);
        end else if (pop_i && cnt_q != '0) begin
            ptr_q <= ptr_q - PW'(1);
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[ptr_q + PW'(1)] <= push_data_i;
    end

    assign top_data_o = mem_q[ptr_q];
    assign empty_o    = cnt_q == '0;
endmodule

// File: rtl/bpu_gshare_ras.sv
// bpu_gshare_ras: gshare predictor with tagged branch table, registered IF-stage lookup and return-address stack
module bpu_gshare_ras
    import bpu_gshare_ras_pkg::*;
#(
    parameter int IDX_W     = 7,
    parameter int HIST_W    = 4,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_wr_i,
    input  logic              if_flush_i,
    input  logic [31:0]       preif_pc_i,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic [31:0]       upd_target_i,
    input  logic [1:0]        upd_type_i,
    input  logic              upd_taken_i,
    input  logic              upd_hit_i,
    input  logic [CNT_W-1:0]  upd_count_i,
    input  logic [HIST_W-1:0] upd_hist_i,
    output logic [31:0]       pred_target_o,
    output logic              pred_taken_o,
    output logic [1:0]        pred_type_o,
    output logic              pred_hit_o,
    output logic [CNT_W-1:0]  pred_count_o,
    output logic [HIST_W-1:0] pred_hist_o,
    output logic              bpu_valid_o
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(1) << (CNT_W - 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        bpu_type_e        typ;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    typedef struct packed {
        logic              valid;
        logic              hit;
        logic              taken;
        bpu_type_e         typ;
        logic [31:0]       target;
        logic [CNT_W-1:0]  cnt;
        logic [HIST_W-1:0] hist;
    } pred_t;

    entry_t            tbl_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [HIST_W-1:0] hist_q, hist_d;
    pred_t             pred_q, pred_d;
    logic [IDX_W-1:0]  ridx, widx;
    entry_t            rd, wr;
    logic              rhit, ras_empty;
    bpu_type_e         rtype, utype;
    logic [31:0]       ras_top;
    logic [CNT_W-1:0]  ucnt;

    always_comb begin
        ridx          = preif_pc_i[IDX_W+1:2] ^ IDX_W'(hist_q);
        rd            = tbl_q[ridx];
        rhit          = vld_q[ridx] && rd.tag == preif_pc_i[31:IDX_W+2];
        rtype         = rhit ? rd.typ : NONE;
        pred_d.valid  = 1'b1;
        pred_d.hit    = rhit;
        pred_d.taken  = rtype == IMME ? rd.cnt[CNT_W-1] : (rtype == CALL || rtype == RETN);
        pred_d.typ    = rtype;
        pred_d.target = !pred_d.taken ? preif_pc_i + PC_STEP :
                        (rtype == RETN && !ras_empty) ? ras_top : rd.target;
        pred_d.cnt    = rhit ? rd.cnt : '0;
        pred_d.hist   = hist_q;
    end

    // Counter trains from the prediction-time snapshot carried down the pipe, not from the table
    always_comb begin
        widx   = upd_pc_i[IDX_W+1:2] ^ IDX_W'(upd_hist_i);
        utype  = bpu_type_e'(upd_type_i);
        ucnt   = !upd_hit_i ? (upd_taken_i ? HALF : HALF - CNT_W'(1)) :
                 upd_taken_i ? (&upd_count_i ? upd_count_i : upd_count_i + CNT_W'(1)) :
                 (|upd_count_i ? upd_count_i - CNT_W'(1) : upd_count_i);
        wr     = '{tag: upd_pc_i[31:IDX_W+2], target: upd_target_i, typ: utype, cnt: ucnt};
        hist_d = (upd_valid_i && utype == IMME) ? HIST_W'({hist_q, upd_taken_i}) : hist_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            hist_q <= '0;
            pred_q <= '0;
        end else begin
            hist_q <= hist_d;
            if (upd_valid_i) vld_q[widx] <= 1'b1;
            if (if_flush_i) pred_q <= '0;
            else if (if_wr_i) pred_q <= pred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid_i) tbl_q[widx] <= wr;
    end

    bpu_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (upd_valid_i && utype == CALL),
        .pop_i       (upd_valid_i && utype == RETN),
        .push_data_i (upd_pc_i + PC_STEP),
        .top_data_o  (ras_top),
        .empty_o     (ras_empty)
    );

    assign pred_target_o = pred_q.target;
    assign pred_taken_o  = pred_q.taken;
    assign pred_type_o   = pred_q.typ;
    assign pred_hit_o    = pred_q.hit;
    assign pred_count_o  = pred_q.cnt;
    assign pred_hist_o   = pred_q.hist;
    assign bpu_valid_o   = pred_q.valid;
endmodule
